clock_adjust_core: RTL and testbench



---
 rtl/clock_adjust_core_pkg.sv | 19 +
 rtl/clock_adjust_core_cnt_modn.sv | 28 ++
 rtl/clock_adjust_core.sv | 90 +++++++++
 tb/tb_clock_adjust_core.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/clock_adjust_core_pkg.sv
// rtl/clock_adjust_core_pkg.sv - shared mode encodings, field widths and idle limit
package clock_adjust_core_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_SEC  = 2'd1,
        MODE_MIN  = 2'd2,
        MODE_HOUR = 2'd3
    } mode_e;

    // The mode selector compares tg_nn against this same value for its timeout.
    localparam int IDLE_MAX_DEF = 20;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int TG_W   = 5;

endpackage

// File: rtl/clock_adjust_core_cnt_modn.sv
// rtl/clock_adjust_core_cnt_modn.sv - modulo-N up counter with wrap strobe
module cnt_modn #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         ckht,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    logic         w_at_max;
    logic [W-1:0] r_q;

    assign w_at_max = (r_q == W'(N - 1));
    assign wrap     = inc & w_at_max;
    assign q        = r_q;

    always_ff @(posedge ckht) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= w_at_max ? '0 : r_q + W'(1);
        end
    end

endmodule

// File: rtl/clock_adjust_core.sv
// rtl/clock_adjust_core.sv - HH:MM:SS timekeeping with per-field adjust and idle-second counter
module clock_adjust_core
    import clock_adjust_core_pkg::*;
#(
    parameter int IDLE_MAX = IDLE_MAX_DEF,
    parameter int HOURS    = 24
) (
    input  logic              ckht,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [1:0]        mode,
    input  logic              ena_up,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [TG_W-1:0]   tg_nn,
    output logic              blink
);

    mode_e            w_mode;
    logic             w_run;
    logic             w_mode_chg;
    logic             w_sec_inc;
    logic             w_min_inc;
    logic             w_hour_inc;
    logic             w_sec_wrap;
    logic             w_min_wrap;
    logic             w_unused_day_wrap;
    logic [1:0]       r_mode_q;
    logic [TG_W-1:0]  r_tg_nn;
    logic             r_blink;

    assign w_mode     = mode_e'(mode);
    assign w_run      = (w_mode == MODE_RUN);
    assign w_mode_chg = (mode != r_mode_q);

    // Run mode chains the carries; adjust modes step only the selected field.
    assign w_sec_inc  = w_run ? tick_1hz   : (ena_up && w_mode == MODE_SEC);
    assign w_min_inc  = w_run ? w_sec_wrap : (ena_up && w_mode == MODE_MIN);
    assign w_hour_inc = w_run ? w_min_wrap : (ena_up && w_mode == MODE_HOUR);

    cnt_modn #(.N(60), .W(SEC_W)) u_sec (
        .ckht (ckht),
        .rst  (rst),
        .inc  (w_sec_inc),
        .q    (sec),
        .wrap (w_sec_wrap)
    );

    cnt_modn #(.N(60), .W(MIN_W)) u_min (
        .ckht (ckht),
        .rst  (rst),
        .inc  (w_min_inc),
        .q    (min),
        .wrap (w_min_wrap)
    );

    cnt_modn #(.N(HOURS), .W(HOUR_W)) u_hour (
        .ckht (ckht),
        .rst  (rst),
        .inc  (w_hour_inc),
        .q    (hour),
        .wrap (w_unused_day_wrap)
    );

    always_ff @(posedge ckht) begin
        if (rst) begin
            r_mode_q <= 2'd0;
            r_tg_nn  <= '0;
            r_blink  <= 1'b1;
        end else begin
            r_mode_q <= mode;
            if (w_run || w_mode_chg || ena_up) begin
                r_tg_nn <= '0;
            end else if (tick_1hz && r_tg_nn != TG_W'(IDLE_MAX)) begin
                r_tg_nn <= r_tg_nn + TG_W'(1);
            end
            // ena_up forces the display on so the freshly stepped value is seen.
            if (w_run || ena_up) begin
                r_blink <= 1'b1;
            end else if (tick_1hz) begin
                r_blink <= ~r_blink;
            end
        end
    end

    assign tg_nn = r_tg_nn;
    assign blink = r_blink;

endmodule

// File: tb/tb_clock_adjust_core.sv
// tb/tb_clock_adjust_core.sv - scoreboard bench for clock_adjust_core
module tb_clock_adjust_core;

    logic       ckht;
    logic       rst;
    logic       tick_1hz;
    logic [1:0] mode;
    logic       ena_up;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [4:0] tg_nn;
    logic       blink;

    typedef struct {
        int s;
        int m;
        int h;
        int tg;
        int b;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    clock_adjust_core dut (
        .ckht     (ckht),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .mode     (mode),
        .ena_up   (ena_up),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .tg_nn    (tg_nn),
        .blink    (blink)
    );

    initial ckht = 1'b0;
    always #5 ckht = ~ckht;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are registered, so each pushed entry is compared at the following negedge.
    always @(negedge ckht) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "sec",   int'(sec),   e.s);
            cmp(nm, "min",   int'(min),   e.m);
            cmp(nm, "hour",  int'(hour),  e.h);
            cmp(nm, "tg_nn", int'(tg_nn), e.tg);
            cmp(nm, "blink", int'(blink), e.b);
        end
    end

    task automatic cyc(input logic [1:0] m, input logic t, input logic u, input logic r,
                       input bit chk, input int es, input int em, input int eh,
                       input int etg, input int eb, input string nm);
        exp_t e;
        mode     = m;
        tick_1hz = t;
        ena_up   = u;
        rst      = r;
        @(posedge ckht);
        #1;
        tick_1hz = 1'b0;
        ena_up   = 1'b0;
        rst      = 1'b0;
        if (chk) begin
            e = '{s: es, m: em, h: eh, tg: etg, b: eb};
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
    endtask

    task automatic ups(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) cyc(m, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, "");
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; mode = 2'd0; ena_up = 1'b0;

        cyc(2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 1, "reset");

        // Preset 23:59:58
        ups(2'd3, 23);
        ups(2'd2, 59);
        ups(2'd1, 57);
        cyc(2'd1, 0, 1, 0, 1, 58, 59, 23, 0, 1, "preset");

        cyc(2'd0, 1, 0, 0, 1, 59, 59, 23, 0, 1, "run_tick1");
        cyc(2'd0, 1, 0, 0, 1, 0, 0, 0, 0, 1, "run_rollover");

        // Adjust seconds wrap without carry
        ups(2'd2, 5);
        ups(2'd1, 58);
        cyc(2'd1, 0, 1, 0, 1, 59, 5, 0, 0, 1, "sec_at_59");
        cyc(2'd1, 1, 0, 0, 1, 59, 5, 0, 1, 0, "adj_tick_frozen");
        cyc(2'd1, 0, 1, 0, 1, 0, 5, 0, 0, 1, "adj_sec_wrap");

        // Idle timeout in minute adjust
        cyc(2'd2, 0, 0, 0, 1, 0, 5, 0, 0, 1, "enter_min");
        for (int i = 1; i <= 25; i++)
            cyc(2'd2, 1, 0, 0, 1, 0, 5, 0, (i > 20) ? 20 : i, (i % 2 == 0) ? 1 : 0, "idle");

        // Collision of ena_up and tick in hour adjust
        cyc(2'd3, 0, 0, 0, 1, 0, 5, 0, 0, 0, "enter_hour");
        for (int i = 1; i <= 7; i++)
            cyc(2'd3, 1, 0, 0, 1, 0, 5, 0, i, (i % 2 == 1) ? 1 : 0, "hour_idle");
        cyc(2'd3, 1, 1, 0, 1, 0, 5, 1, 0, 1, "collision");

        // Mode change clears tg_nn; run resumes from frozen time
        cyc(2'd1, 0, 0, 0, 1, 0, 5, 1, 0, 1, "enter_sec");
        for (int i = 1; i <= 12; i++)
            cyc(2'd1, 1, 0, 0, 1, 0, 5, 1, i, (i % 2 == 0) ? 1 : 0, "sec_idle");
        cyc(2'd2, 0, 0, 0, 1, 0, 5, 1, 0, 1, "mode_chg_clear");
        cyc(2'd0, 0, 0, 0, 1, 0, 5, 1, 0, 1, "back_to_run");
        cyc(2'd0, 1, 0, 0, 1, 1, 5, 1, 0, 1, "run_resume");
        cyc(2'd0, 0, 1, 0, 1, 1, 5, 1, 0, 1, "run_ignores_up");

        // Reset mid-adjust at 12:34:56 with a coincident tick
        ups(2'd3, 11);
        ups(2'd2, 29);
        ups(2'd1, 55);
        cyc(2'd3, 0, 0, 0, 1, 56, 34, 12, 0, 1, "preset_123456");
        cyc(2'd3, 1, 0, 0, 1, 56, 34, 12, 1, 0, "pre_reset_tick");
        cyc(2'd3, 1, 0, 1, 1, 0, 0, 0, 0, 1, "reset_mid_adjust");
        cyc(2'd0, 1, 0, 0, 1, 1, 0, 0, 0, 1, "run_after_reset");

        // Hour wraps 23 -> 0 in adjust without touching minutes
        ups(2'd3, 23);
        cyc(2'd3, 0, 0, 0, 1, 1, 0, 23, 0, 1, "hour_at_23");
        cyc(2'd3, 0, 1, 0, 1, 1, 0, 0, 0, 1, "hour_adj_wrap");

        repeat (2) @(negedge ckht);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
